// File: rtl/eb_pkg.sv
// Shared types and width helpers for the elastic-buffer FIFO.
// Occupancy classification plus pointer/level sizing used by eb_fifo.
package eb_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_state_t;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // One extra bit so the level can represent DEPTH itself.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/eb_regfile.sv
// WIDTH x DEPTH flop storage with one synchronous write port and one
// asynchronous read port; contents are intentionally not reset.
module eb_regfile
    import eb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/eb_fifo.sv
// Elastic-buffer FIFO: registered-only ready/valid handshakes, occupancy
// tracked as a level counter with an EMPTY/PARTIAL/FULL classification.
module eb_fifo
    import eb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       t0_data,
    input  logic                   t0_valid,
    output logic                   t0_ready,
    output logic [WIDTH-1:0]       i0_data,
    output logic                   i0_valid,
    input  logic                   i0_ready,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    generate
        if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("eb_fifo: DEPTH must be a power of two in 2..256");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
            $error("eb_fifo: AF_THRESH must be in 1..DEPTH");
        end
    endgenerate

    occ_state_t       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push;
    logic             pop;

    // Handshake outputs come straight from the state register so neither
    // side ever sees a combinational path from the other.
    assign t0_ready    = (state_q != FULL);
    assign i0_valid    = (state_q != EMPTY);
    assign level       = level_q;
    assign almost_full = (level_q >= LVL_W'(AF_THRESH));

    assign push = t0_valid && t0_ready && !flush;
    assign pop  = i0_valid && i0_ready && !flush;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
        if (level_d == '0) begin
            state_d = EMPTY;
        end else if (level_d == LVL_W'(DEPTH)) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    eb_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (t0_data),
        .raddr (rd_ptr_q),
        .rdata (i0_data)
    );

endmodule

// File: tb/tb_eb_fifo.sv
// Scoreboard testbench for eb_fifo (WIDTH=8, DEPTH=4, AF_THRESH=3).
module tb_eb_fifo;

    logic       clk;
    logic       reset_n;
    logic [7:0] t0_data;
    logic       t0_valid;
    logic       t0_ready;
    logic [7:0] i0_data;
    logic       i0_valid;
    logic       i0_ready;
    logic       flush;
    logic [2:0] level;
    logic       almost_full;

    int         n_compared;
    int         n_mismatched;
    logic [7:0] sb_q[$];

    eb_fifo #(
        .WIDTH     (8),
        .DEPTH     (4),
        .AF_THRESH (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .t0_data     (t0_data),
        .t0_valid    (t0_valid),
        .t0_ready    (t0_ready),
        .i0_data     (i0_data),
        .i0_valid    (i0_valid),
        .i0_ready    (i0_ready),
        .flush       (flush),
        .level       (level),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One cycle: drive at the falling edge, check against the queue model,
    // then let the model take the push/pop that the next rising edge performs.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic f);
        logic alt_ready;
        logic exp_ready;
        logic exp_valid;
        @(negedge clk);
        t0_valid = v;
        t0_data  = d;
        flush    = f;
        i0_ready = ~r;
        #1;
        alt_ready = t0_ready;
        i0_ready  = r;
        #1;
        exp_ready = (sb_q.size() != 4);
        exp_valid = (sb_q.size() != 0);
        checkOutput("t0_ready_alt_i0_ready", int'(alt_ready), int'(exp_ready));
        checkOutput("t0_ready", int'(t0_ready), int'(exp_ready));
        checkOutput("i0_valid", int'(i0_valid), int'(exp_valid));
        checkOutput("level", int'(level), sb_q.size());
        checkOutput("almost_full", int'(almost_full), int'(sb_q.size() >= 3));
        if (f) begin
            sb_q.delete();
        end else begin
            if (r && exp_valid) begin
                checkOutput("i0_data", int'(i0_data), int'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (v && exp_ready) begin
                sb_q.push_back(d);
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset_n  = 1'b0;
        t0_valid = 1'b0;
        t0_data  = 8'h00;
        i0_ready = 1'b0;
        flush    = 1'b0;

        #2;
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_t0_ready", int'(t0_ready), 1);
        checkOutput("reset_i0_valid", int'(i0_valid), 0);
        checkOutput("reset_almost_full", int'(almost_full), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] fill to FULL, fifth beat ignored");
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);

        $display("[TB] drain from FULL");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] stream ten beats");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] flush at level 2");
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] asynchronous reset at level 3");
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB3, 1'b0, 1'b0);
        @(negedge clk);
        t0_valid = 1'b0;
        #1;
        checkOutput("level_before_reset", int'(level), sb_q.size());
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_level", int'(level), 0);
        checkOutput("async_i0_valid", int'(i0_valid), 0);
        checkOutput("async_t0_ready", int'(t0_ready), 1);
        checkOutput("async_almost_full", int'(almost_full), 0);
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
